// File: rtl/floo_reduction_offload_responder.sv
// Elastic, fully pipelined integer reduction unit answering the router's narrow
// reduction offload port: one operand pair plus op code in, one result out.
module floo_reduction_offload_responder #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned NumStages = 3,
  parameter int unsigned CntWidth  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic [2:0]           req_op_i,
  input  logic [DataWidth-1:0] req_operand1_i,
  input  logic [DataWidth-1:0] req_operand2_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  output logic [DataWidth-1:0] resp_result_o,
  output logic                 resp_err_o,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 busy_o,
  output logic [CntWidth-1:0]  op_count_o
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_MUL  = 3'd1,
    OP_MAX  = 3'd2,
    OP_MIN  = 3'd3,
    OP_MAXU = 3'd4,
    OP_MINU = 3'd5
  } op_e;

  logic [NumStages-1:0] valid_q;
  logic [NumStages-1:0] err_q;
  logic [DataWidth-1:0] result_q [NumStages];
  logic [NumStages-1:0] stage_ready;
  logic [CntWidth-1:0]  count_q;
  logic [DataWidth-1:0] alu_result;
  logic                 alu_err;
  logic                 resp_handshake;

  always_comb begin
    alu_result = '0;
    alu_err    = 1'b0;
    case (op_e'(req_op_i))
      OP_ADD:  alu_result = req_operand1_i + req_operand2_i;
      OP_MUL:  alu_result = req_operand1_i * req_operand2_i;
      OP_MAX:  alu_result = ($signed(req_operand1_i) > $signed(req_operand2_i)) ?
                            req_operand1_i : req_operand2_i;
      OP_MIN:  alu_result = ($signed(req_operand1_i) < $signed(req_operand2_i)) ?
                            req_operand1_i : req_operand2_i;
      OP_MAXU: alu_result = (req_operand1_i > req_operand2_i) ? req_operand1_i : req_operand2_i;
      OP_MINU: alu_result = (req_operand1_i < req_operand2_i) ? req_operand1_i : req_operand2_i;
      default: alu_err    = 1'b1;
    endcase
  end

  // Stage i can take new data unless it and every stage after it are occupied
  // while the output is stalled; computed flat to avoid a self-referencing chain.
  always_comb begin
    logic full;
    full        = 1'b0;
    stage_ready = '0;
    for (int unsigned i = 0; i < NumStages; i++) begin
      full = 1'b1;
      for (int unsigned j = i; j < NumStages; j++) begin
        full = full & valid_q[j];
      end
      stage_ready[i] = !(full && !resp_ready_i);
    end
  end

  assign req_ready_o    = stage_ready[0] && !flush_i;
  assign resp_valid_o   = valid_q[NumStages-1];
  assign resp_result_o  = result_q[NumStages-1];
  assign resp_err_o     = err_q[NumStages-1];
  assign busy_o         = |valid_q;
  assign op_count_o     = count_q;
  assign resp_handshake = resp_valid_o && resp_ready_i && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      err_q   <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < NumStages; i++) begin
        result_q[i] <= '0;
      end
    end else begin
      if (resp_handshake) begin
        count_q <= count_q + 1'b1;
      end
      if (flush_i) begin
        valid_q <= '0;
      end else begin
        if (stage_ready[0]) begin
          valid_q[0] <= req_valid_i;
          if (req_valid_i) begin
            result_q[0] <= alu_result;
            err_q[0]    <= alu_err;
          end
        end
        // Payload only moves with a valid entry so stalled/idle outputs hold their data.
        for (int unsigned i = 1; i < NumStages; i++) begin
          if (stage_ready[i]) begin
            valid_q[i] <= valid_q[i-1];
            if (valid_q[i-1]) begin
              result_q[i] <= result_q[i-1];
              err_q[i]    <= err_q[i-1];
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/floo_reduction_offload_responder.md
Name: floo_reduction_offload_responder

Overview:
- Responder end of the router's narrow reduction offload port. The router acts as initiator: it issues an operand pair plus an operation code; this block returns one result per request.
- Elastic, fully pipelined integer reduction unit with a configurable number of stages.
- Accepts one request per cycle and applies backpressure stage by stage.
- Instantiated next to `floo_nw_router` inside the tile, in place of the single-cycle ALU.

Parameters:
- DataWidth, 64, operand/result width in bits (≥8).
- NumStages, 3, pipeline register stages (≥1); sets fixed latency.
- CntWidth, 32, width of completed-operation counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  synchronous clear of all in-flight operations.
- req_op_i  in  3  operation code.
- req_operand1_i  in  DataWidth  first operand.
- req_operand2_i  in  DataWidth  second operand.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- resp_result_o  out  DataWidth  result.
- resp_err_o  out  1  unsupported op code flag, travels with the result.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response ready.
- busy_o  out  1  any stage holds a valid entry.
- op_count_o  out  CntWidth  number of completed response handshakes.

Behaviour:
- Clock and reset:
  - Single clock domain `clk_i`. Reset `rst_i` is synchronous and active-high, sampled on the rising edge of `clk_i`.
  - Reset values: all stage valid bits 0, so `resp_valid_o=0` and `busy_o=0`. `resp_result_o=0`, `resp_err_o=0`, `op_count_o=0`. `req_ready_o=1` from the first cycle after reset.
- Handshakes:
  - A transfer happens when valid && ready on a rising edge.
  - Once `resp_valid_o` is asserted, it and the response data stay stable until `resp_ready_i`.
  - Requests that arrive before ready is high are held by the initiator; the block never drops them.
- Op codes (computed combinationally at input, registered into stage 0):
  - 0 ADD: wrapping sum modulo 2^DataWidth.
  - 1 MUL: low DataWidth bits of the product.
  - 2 MAX: signed maximum.
  - 3 MIN: signed minimum.
  - 4 MAXU: unsigned maximum.
  - 5 MINU: unsigned minimum.
  - 6, 7: result 0, `resp_err_o=1`.
- Pipeline:
  - Stages s0..s(NumStages-1), each holding a valid bit, a result and an err bit.
  - Stage s(N-1) drives the response outputs.
  - Stage i advances when its successor is empty or advancing; the last stage advances on `resp_ready_i`.
  - `req_ready_o = !s0.valid || s0 advances`. This is a combinational chain from `resp_ready_i`, so throughput is 1 op/cycle with no bubbles.
  - Latency: a request accepted at edge k gives `resp_valid_o` high after edge k+NumStages-1 when no stalls occur. With NumStages=1, `resp_valid_o` is high in the cycle right after acceptance.
  - Ordering: strictly in-order.
  - Capacity: NumStages entries. With `resp_ready_i=0`, at most NumStages requests are accepted, then `req_ready_o=0`.
  - Stalled entries keep their data unchanged. Bubbles collapse when downstream stalls.
- Simultaneous events: on one edge, a request accept and a response handshake with a full pipeline are both legal; occupancy stays constant.
- `flush_i`:
  - Clears all valid bits on the edge.
  - `req_ready_o` is forced to 0 during the flush cycle, so no accept happens.
  - A response handshake in the flush cycle does not count.
  - `op_count_o` is kept.
- Reset mid-operation: all entries are discarded and `op_count_o` is cleared. A response pending at reset is lost; no handshake is counted on that edge.
- `op_count_o`: increments by 1 on each response handshake and wraps at 2^CntWidth.
- `busy_o`: OR of all stage valid bits.

Test Plan:
- Single ops, NumStages=3, DataWidth=64, `resp_ready_i=1`:
  - ADD 0xFFFF_FFFF_FFFF_FFFF+2 → 0x1, `resp_valid_o` 3 cycles after accept.
  - MUL 7*6 → 42.
- Signed vs unsigned: operands 0x8000_0000_0000_0000 and 0x1:
  - MAX → 0x1, MIN → 0x8000_0000_0000_0000.
  - MAXU → 0x8000_0000_0000_0000, MINU → 0x1.
  - Op 6 → result 0 with `resp_err_o=1`.
- Throughput: 10 back-to-back ADD i+i (i=0..9) → responses 0,2,…,18 in order on 10 consecutive cycles; `op_count_o=10`.
- Backpressure: `resp_ready_i=0`, stream requests → exactly 3 accepted, then `req_ready_o=0`. First response held stable. Release → 3 results in order and `req_ready_o` reasserts the same cycle.
- Random stalls on both sides, 1000 random ops vs reference model → all results match and stay in order; `busy_o=0` at end.
- Flush with 2 in flight → no responses afterwards, `busy_o=0` next cycle, `op_count_o` unchanged. Then `rst_i` mid-stream → all outputs at reset values the next cycle.
